// File: rtl/sid_mixer_seq.sv
// sid_mixer_seq: time-multiplexed N-voice SID mixer with filter routing, DC offset, clipping and master volume.
// Optional SID_MIXER_DITHER_EN adds 1-LSB LFSR dither ahead of the volume shift.
module sid_mixer_seq #(
    parameter int NUM_VOICES = 3,
    parameter int VOICE_W    = 16,
    parameter int OUT_W      = 16,
    parameter int HEADROOM   = 3,
    parameter int DC_OFFSET  = -3746,
    parameter int BASE_ADDR  = 'h17
) (
    input  logic                          clk,
    input  logic                          iRstN,
    input  logic                          clkEn,
    input  logic                          iWE,
    input  logic [4:0]                    iAddr,
    input  logic [7:0]                    iDataW,
    input  logic [NUM_VOICES*VOICE_W-1:0] iVoices,
    input  logic [OUT_W-1:0]              iFiltLP,
    input  logic [OUT_W-1:0]              iFiltBP,
    input  logic [OUT_W-1:0]              iFiltHP,
    output logic [OUT_W-1:0]              oPreFilter,
    output logic                          oPreValid,
    output logic [OUT_W-1:0]              oOut,
    output logic                          oValid,
    output logic                          oBusy,
    output logic                          oOverrun
);
    localparam int ACC_W = OUT_W + 4;
    localparam int IW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam logic [4:0] A0 = 5'(BASE_ADDR);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] DC = ACC_W'(DC_OFFSET);

    typedef enum logic [2:0] {IDLE, ACCUM, PRE, POST, VOL} state_t;
    state_t state, state_nxt;

    logic [IW-1:0]                   idx;
    logic [NUM_VOICES-1:0]           reg_filt, reg_mute, s_filt, s_mute;
    logic [2:0]                      reg_mode, s_mode;
    logic                            reg_off, s_off;
    logic [3:0]                      reg_vol, s_vol;
    logic [NUM_VOICES*VOICE_W-1:0]   s_voices;
    logic signed [VOICE_W-1:0]       vsel;
    logic signed [ACC_W-1:0]         filt_acc, byp_acc, filt_nxt, byp_nxt, v, post, prod;
    logic [OUT_W-1:0]                clipped;
    logic                            last, live;

    function automatic logic signed [ACC_W-1:0] ext(input logic [OUT_W-1:0] x);
        return {{(ACC_W-OUT_W){x[OUT_W-1]}}, x};
    endfunction

    function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        return a > MAXV ? MAXV[OUT_W-1:0] : a < MINV ? MINV[OUT_W-1:0] : a[OUT_W-1:0];
    endfunction

    assign oBusy    = state != IDLE;
    assign oOverrun = clkEn && state != IDLE;

    // Live control registers; a running mix only sees the snapshot taken in IDLE.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            reg_filt <= '0;
            reg_mute <= '0;
            reg_mode <= '0;
            reg_off  <= 1'b0;
            reg_vol  <= 4'hF;
        end else if (iWE) begin
            if (iAddr == A0) reg_filt <= iDataW[NUM_VOICES-1:0];
            if (iAddr == A0 + 5'd1) {reg_off, reg_mode, reg_vol} <= iDataW;
            if (iAddr == A0 + 5'd2) reg_mute <= iDataW[NUM_VOICES-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) state <= IDLE;
        else state <= state_nxt;
    end

    // Sequencing: one voice per clk, then pre-filter, post-filter and volume steps.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clkEn) state_nxt = ACCUM;
            ACCUM:   if (last) state_nxt = PRE;
            PRE:     state_nxt = POST;
            POST:    state_nxt = VOL;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-voice routing, post-filter sum, clip and volume product.
    always_comb begin
        vsel     = s_voices[idx*VOICE_W +: VOICE_W];
        v        = $signed({{(ACC_W-VOICE_W){vsel[VOICE_W-1]}}, vsel}) >>> HEADROOM;
        live     = !s_mute[idx];
        last     = idx == IW'(NUM_VOICES - 1);
        filt_nxt = filt_acc + ((live && s_filt[idx]) ? v : '0);
        byp_nxt  = byp_acc + ((live && !s_filt[idx] && !(last && s_off)) ? v : '0);
        post     = byp_acc + DC + (s_mode[0] ? ext(iFiltLP) : '0)
                 + (s_mode[1] ? ext(iFiltBP) : '0) + (s_mode[2] ? ext(iFiltHP) : '0);
        clipped  = sat(post);
`ifdef SID_MIXER_DITHER_EN
        prod     = ext(clipped) * $signed({{(ACC_W-4){1'b0}}, s_vol})
                 + $signed({{(ACC_W-4){1'b0}}, lfsr[3:0]});
`else
        prod     = ext(clipped) * $signed({{(ACC_W-4){1'b0}}, s_vol});
`endif
    end

    // Snapshot, accumulation and registered outputs; a reset mid-sample drops the sample.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            idx        <= '0;
            s_filt     <= '0;
            s_mute     <= '0;
            s_mode     <= '0;
            s_off      <= 1'b0;
            s_vol      <= '0;
            s_voices   <= '0;
            filt_acc   <= '0;
            byp_acc    <= '0;
            oPreFilter <= '0;
            oOut       <= '0;
            oPreValid  <= 1'b0;
            oValid     <= 1'b0;
        end else begin
            oPreValid <= state == ACCUM && last;
            oValid    <= state == POST;
            if (state == IDLE && clkEn) begin
                s_voices <= iVoices;
                s_filt   <= reg_filt;
                s_mute   <= reg_mute;
                s_mode   <= reg_mode;
                s_off    <= reg_off;
                s_vol    <= reg_vol;
                filt_acc <= '0;
                byp_acc  <= '0;
                idx      <= '0;
            end
            if (state == ACCUM) begin
                filt_acc <= filt_nxt;
                byp_acc  <= byp_nxt;
                idx      <= idx + 1'b1;
                if (last) oPreFilter <= sat(filt_nxt);
            end
            if (state == POST) oOut <= prod[ACC_W-1:4];
        end
    end

`ifdef SID_MIXER_DITHER_EN
    logic [15:0] lfsr;

    // Dither source, stepped once per output sample.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) lfsr <= 16'hACE1;
        else if (state == POST) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
`endif
endmodule
